// File: rtl/upd1771c_tone_mixer.sv
`timescale 1ns/1ps
// uPD1771C audio back-end: NCH programmable tone channels plus one LFSR noise
// channel, summed by a saturating mixer into a sign-magnitude PCM sample per TICK.
module upd1771c_tone_mixer #(
  parameter int NCH       = 4,
  parameter int PER_W     = 12,
  parameter int VOL_W     = 4,
  parameter int OUT_W     = 8,
  parameter int MIX_SHIFT = 2
) (
  input  logic             CLK,
  input  logic             RESB,
  input  logic             TICK,
  input  logic             WR_EN,
  input  logic [3:0]       WR_CH,
  input  logic [1:0]       WR_REG,
  input  logic [7:0]       WR_DATA,
  input  logic             TONE_IE,
  input  logic             IRQ_ACK,
  output logic             IRQ,
  output logic             PCM_VALID,
  output logic             PCM_NEG,
  output logic [OUT_W-1:0] PCM_OUT
);

  localparam int NC    = NCH + 1;
  localparam int VAL_W = VOL_W + 1;
  localparam int SUM_A = VAL_W + 4 + MIX_SHIFT;
  localparam int SUM_W = (SUM_A > OUT_W) ? SUM_A : OUT_W + 1;

  logic [PER_W-1:0] per_q [NC];
  logic [PER_W-1:0] per_d [NC];
  logic [PER_W-1:0] cnt_q [NC];
  logic [PER_W-1:0] cnt_d [NC];
  logic [VOL_W-1:0] vol_q [NC];
  logic [VOL_W-1:0] vol_d [NC];
  logic [5:0]       ph_q  [NC];
  logic [5:0]       ph_d  [NC];
  logic [NC-1:0]    en_q, en_d, wave_q, wave_d, m64_q, m64_d, expire;
  logic [14:0]      lfsr_q, lfsr_d;
  logic             irq_q, irq_d, tick_q, tick_d;
  logic             pcm_valid_q, pcm_valid_d, pcm_neg_q, pcm_neg_d;
  logic [OUT_W-1:0] pcm_out_q, pcm_out_d;

  logic signed [VAL_W-1:0] sv, val_c;
  logic signed [3:0]       s4;
  logic signed [VAL_W+3:0] prod, prod_sh;
  logic signed [SUM_W-1:0] sum, mix;

  function automatic logic [OUT_W-1:0] sat_mag(input logic signed [SUM_W-1:0] x);
    logic [SUM_W-1:0] mag;
    mag = x[SUM_W-1] ? unsigned'(-x) : unsigned'(x);
    if ((mag >> OUT_W) != '0) return '1;
    return mag[OUT_W-1:0];
  endfunction

  always_comb begin : next_state
    per_d  = per_q;
    cnt_d  = cnt_q;
    vol_d  = vol_q;
    ph_d   = ph_q;
    en_d   = en_q;
    wave_d = wave_q;
    m64_d  = m64_q;
    lfsr_d = lfsr_q;
    expire = '0;
    tick_d = TICK;
    for (int c = 0; c < NC; c++) begin
      if (TICK && en_q[c] && per_q[c] != '0) begin
        if (cnt_q[c] <= PER_W'(1)) begin
          expire[c] = 1'b1;
          cnt_d[c]  = per_q[c];
          ph_d[c]   = m64_q[c] ? ph_q[c] + 6'd1 : {1'b0, ph_q[c][4:0] + 5'd1};
        end else begin
          cnt_d[c] = cnt_q[c] - PER_W'(1);
        end
      end
    end
    if (expire[NCH]) lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    irq_d = (expire[0] && ph_d[0] == 6'd0 && TONE_IE) || (irq_q && !IRQ_ACK);
    // Register writes follow the tick update so the reload above sees the old period.
    for (int c = 0; c < NC; c++) begin
      if (WR_EN && WR_CH == 4'(c)) begin
        case (WR_REG)
          2'd0: per_d[c][7:0]       = WR_DATA;
          2'd1: per_d[c][PER_W-1:8] = WR_DATA[PER_W-9:0];
          2'd2: vol_d[c]            = WR_DATA[VOL_W-1:0];
          default: begin
            en_d[c]   = WR_DATA[0];
            wave_d[c] = WR_DATA[1];
            m64_d[c]  = WR_DATA[2];
            if (WR_DATA[3]) begin
              ph_d[c]  = 6'd0;
              cnt_d[c] = per_q[c];
            end else if (!en_q[c] && WR_DATA[0]) begin
              cnt_d[c] = per_q[c];
            end
          end
        endcase
      end
    end
  end

  always_comb begin : mixer
    sum     = '0;
    sv      = '0;
    s4      = '0;
    prod    = '0;
    prod_sh = '0;
    val_c   = '0;
    for (int c = 0; c < NC; c++) begin
      sv      = signed'({1'b0, vol_q[c]});
      s4      = m64_q[c] ? ph_q[c][5:2] : ph_q[c][4:1];
      prod    = {{VAL_W{s4[3]}}, s4} * {{4{sv[VAL_W-1]}}, sv};
      prod_sh = prod >>> 3;
      if (!en_q[c] || per_q[c] == '0) begin
        val_c = '0;
      end else if (c == NCH) begin
        val_c = lfsr_q[0] ? sv : -sv;
      end else if (wave_q[c]) begin
        val_c = prod_sh[VAL_W-1:0];
      end else begin
        val_c = (m64_q[c] ? ph_q[c][5] : ph_q[c][4]) ? -sv : sv;
      end
      sum = sum + {{(SUM_W-VAL_W){val_c[VAL_W-1]}}, val_c};
    end
    mix = sum <<< MIX_SHIFT;
  end

  // Output stage: sample the post-tick state one cycle after TICK.
  always_comb begin : pcm_next
    pcm_valid_d = tick_q;
    pcm_neg_d   = pcm_neg_q;
    pcm_out_d   = pcm_out_q;
    if (tick_q) begin
      pcm_neg_d = mix[SUM_W-1];
      pcm_out_d = sat_mag(mix);
    end
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      for (int c = 0; c < NC; c++) begin
        per_q[c] <= '0;
        cnt_q[c] <= '0;
        vol_q[c] <= '0;
        ph_q[c]  <= '0;
      end
      en_q        <= '0;
      wave_q      <= '0;
      m64_q       <= '0;
      lfsr_q      <= 15'h7FFF;
      irq_q       <= 1'b0;
      tick_q      <= 1'b0;
      pcm_valid_q <= 1'b0;
      pcm_neg_q   <= 1'b0;
      pcm_out_q   <= '0;
    end else begin
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      vol_q       <= vol_d;
      ph_q        <= ph_d;
      en_q        <= en_d;
      wave_q      <= wave_d;
      m64_q       <= m64_d;
      lfsr_q      <= lfsr_d;
      irq_q       <= irq_d;
      tick_q      <= tick_d;
      pcm_valid_q <= pcm_valid_d;
      pcm_neg_q   <= pcm_neg_d;
      pcm_out_q   <= pcm_out_d;
    end
  end

  assign IRQ       = irq_q;
  assign PCM_VALID = pcm_valid_q;
  assign PCM_NEG   = pcm_neg_q;
  assign PCM_OUT   = pcm_out_q;

endmodule

// File: tb/tb_upd1771c_tone_mixer.sv
`timescale 1ns/1ps
// Directed bench for upd1771c_tone_mixer with default parameters (MIX_SHIFT=2).
module tb_upd1771c_tone_mixer;

  logic       CLK = 1'b0;
  logic       RESB = 1'b0;
  logic       TICK = 1'b0;
  logic       WR_EN = 1'b0;
  logic [3:0] WR_CH = '0;
  logic [1:0] WR_REG = '0;
  logic [7:0] WR_DATA = '0;
  logic       TONE_IE = 1'b0;
  logic       IRQ_ACK = 1'b0;
  logic       IRQ, PCM_VALID, PCM_NEG;
  logic [7:0] PCM_OUT;

  int checks = 0;
  int failures = 0;
  int saw_tab [16] = '{0, 1, 3, 5, 7, 9, 11, 13, -15, -14, -12, -10, -8, -6, -4, -2};

  upd1771c_tone_mixer dut (
    .CLK(CLK), .RESB(RESB), .TICK(TICK), .WR_EN(WR_EN), .WR_CH(WR_CH),
    .WR_REG(WR_REG), .WR_DATA(WR_DATA), .TONE_IE(TONE_IE), .IRQ_ACK(IRQ_ACK),
    .IRQ(IRQ), .PCM_VALID(PCM_VALID), .PCM_NEG(PCM_NEG), .PCM_OUT(PCM_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic apply_reset();
    @(negedge CLK);
    RESB = 1'b0; TONE_IE = 1'b0; IRQ_ACK = 1'b0; TICK = 1'b0; WR_EN = 1'b0;
    repeat (2) @(negedge CLK);
    RESB = 1'b1;
  endtask

  task automatic wr(input logic [3:0] ch, input logic [1:0] rg, input logic [7:0] d);
    @(negedge CLK);
    WR_EN = 1'b1; WR_CH = ch; WR_REG = rg; WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic do_tick(input logic ack, output logic v0, output logic v1, output logic v2);
    @(negedge CLK);
    TICK = 1'b1; IRQ_ACK = ack;
    @(negedge CLK);
    TICK = 1'b0; IRQ_ACK = 1'b0; v0 = PCM_VALID;
    @(negedge CLK);
    v1 = PCM_VALID;
    @(negedge CLK);
    v2 = PCM_VALID;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (IRQ !== 1'b0 || PCM_OUT !== 8'd0 || PCM_NEG !== 1'b0 || PCM_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got irq=%b out=%0d neg=%b vld=%b exp 0/0/0/0", IRQ, PCM_OUT, PCM_NEG, PCM_VALID);
    end
  endtask

  task automatic test_square();
    logic v0, v1, v2, eneg;
    apply_reset();
    wr(4'd0, 2'd0, 8'd2);
    wr(4'd0, 2'd2, 8'd15);
    wr(4'd0, 2'd3, 8'h01);
    for (int k = 1; k <= 95; k++) begin
      do_tick(1'b0, v0, v1, v2);
      eneg = (((k / 2) % 32) >= 16);
      checks++;
      if (v0 !== 1'b0 || v1 !== 1'b1 || v2 !== 1'b0) begin
        failures++;
        $display("FAIL square_valid tick=%0d got=%b%b%b exp=010", k, v0, v1, v2);
      end
      checks++;
      if (PCM_OUT !== 8'd60 || PCM_NEG !== eneg) begin
        failures++;
        $display("FAIL square_pcm tick=%0d got=%0d/%b exp=60/%b", k, PCM_OUT, PCM_NEG, eneg);
      end
    end
    // Asynchronous reset mid-tone, away from any clock edge.
    @(negedge CLK);
    #2 RESB = 1'b0;
    #1;
    checks++;
    if (IRQ !== 1'b0 || PCM_OUT !== 8'd0 || PCM_NEG !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got irq=%b out=%0d neg=%b exp 0/0/0", IRQ, PCM_OUT, PCM_NEG);
    end
    @(negedge CLK);
    RESB = 1'b1;
    do_tick(1'b0, v0, v1, v2);
    checks++;
    if (PCM_OUT !== 8'd0 || PCM_NEG !== 1'b0 || v1 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_tick got out=%0d neg=%b vld=%b exp 0/0/1", PCM_OUT, PCM_NEG, v1);
    end
  endtask

  task automatic test_saw();
    logic v0, v1, v2, eneg;
    int ev;
    logic [7:0] emag;
    apply_reset();
    wr(4'd1, 2'd0, 8'd1);
    wr(4'd1, 2'd2, 8'd15);
    wr(4'd1, 2'd3, 8'h03);
    for (int k = 1; k <= 34; k++) begin
      do_tick(1'b0, v0, v1, v2);
      ev   = 4 * saw_tab[(k % 32) / 2];
      eneg = (ev < 0);
      emag = 8'(eneg ? -ev : ev);
      checks++;
      if (PCM_OUT !== emag || PCM_NEG !== eneg) begin
        failures++;
        $display("FAIL saw_pcm tick=%0d got=%0d/%b exp=%0d/%b", k, PCM_OUT, PCM_NEG, emag, eneg);
      end
    end
  endtask

  task automatic test_noise();
    logic v0, v1, v2, eneg;
    apply_reset();
    wr(4'd4, 2'd0, 8'd1);
    wr(4'd4, 2'd2, 8'd8);
    wr(4'd4, 2'd3, 8'h01);
    for (int k = 1; k <= 16; k++) begin
      do_tick(1'b0, v0, v1, v2);
      eneg = (k != 15);
      checks++;
      if (PCM_OUT !== 8'd32 || PCM_NEG !== eneg) begin
        failures++;
        $display("FAIL noise_pcm tick=%0d got=%0d/%b exp=32/%b", k, PCM_OUT, PCM_NEG, eneg);
      end
    end
  endtask

  task automatic test_saturation();
    logic v0, v1, v2;
    apply_reset();
    for (int c = 0; c <= 4; c++) begin
      wr(4'(c), 2'd0, 8'd100);
      wr(4'(c), 2'd2, 8'd15);
      wr(4'(c), 2'd3, 8'h01);
    end
    do_tick(1'b0, v0, v1, v2);
    checks++;
    if (PCM_OUT !== 8'd255 || PCM_NEG !== 1'b0) begin
      failures++;
      $display("FAIL saturation got=%0d/%b exp=255/0", PCM_OUT, PCM_NEG);
    end
    for (int c = 1; c <= 4; c++) wr(4'(c), 2'd3, 8'h00);
    do_tick(1'b0, v0, v1, v2);
    checks++;
    if (PCM_OUT !== 8'd60 || PCM_NEG !== 1'b0) begin
      failures++;
      $display("FAIL single_after_disable got=%0d/%b exp=60/0", PCM_OUT, PCM_NEG);
    end
    wr(4'd0, 2'd0, 8'd0);
    do_tick(1'b0, v0, v1, v2);
    checks++;
    if (PCM_OUT !== 8'd0 || PCM_NEG !== 1'b0) begin
      failures++;
      $display("FAIL zero_period got=%0d/%b exp=0/0", PCM_OUT, PCM_NEG);
    end
  endtask

  task automatic test_irq();
    logic v0, v1, v2, eirq;
    apply_reset();
    TONE_IE = 1'b1;
    wr(4'd0, 2'd0, 8'd1);
    wr(4'd0, 2'd3, 8'h01);
    for (int k = 1; k <= 64; k++) begin
      do_tick(k == 64, v0, v1, v2);
      eirq = (k >= 32);
      checks++;
      if (IRQ !== eirq) begin
        failures++;
        $display("FAIL irq_tick tick=%0d got=%b exp=%b", k, IRQ, eirq);
      end
    end
    @(negedge CLK);
    TONE_IE = 1'b0;
    @(negedge CLK);
    checks++;
    if (IRQ !== 1'b1) begin
      failures++;
      $display("FAIL irq_ie_drop got=%b exp=1", IRQ);
    end
    IRQ_ACK = 1'b1;
    @(negedge CLK);
    IRQ_ACK = 1'b0;
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL irq_lone_ack got=%b exp=0", IRQ);
    end
  endtask

  task automatic test_bad_channel();
    logic v0, v1, v2;
    wr(4'd9, 2'd0, 8'd1);
    wr(4'd9, 2'd2, 8'd15);
    wr(4'd9, 2'd3, 8'h01);
    wr(4'd5, 2'd2, 8'd15);
    do_tick(1'b0, v0, v1, v2);
    checks++;
    if (PCM_OUT !== 8'd0 || PCM_NEG !== 1'b0 || IRQ !== 1'b0) begin
      failures++;
      $display("FAIL bad_channel got out=%0d neg=%b irq=%b exp 0/0/0", PCM_OUT, PCM_NEG, IRQ);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_saw();
    test_noise();
    test_saturation();
    test_irq();
    test_bad_channel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
